alu_uart_if: RTL and testbench

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_uart_if.sv | 166 ++++++++++++++++
 tb/tb_alu_uart_if.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_uart_if.sv
// -----------------------------------------------------------------------------
// alu_uart_if
// Glue between a UART receiver/transmitter pair and a combinational ALU.
// Three received bytes are forwarded in turn as operand A, operand B and the
// opcode, each with its own one-hot load strobe. The ALU result is then
// captured and handed to the transmitter, which is started once it is idle.
//
// Ports
//   i_clock       system clock, all state on the rising edge
//   i_reset       asynchronous active-low reset
//   i_rx_data     received byte, valid while i_rx_done=1
//   i_rx_done     one-cycle pulse per received byte
//   o_alu_data    operand/opcode byte to the ALU (held between strobes)
//   o_alu_valid   one-hot load strobe: bit0=A, bit1=B, bit2=opcode
//   i_alu_result  combinational ALU result
//   o_tx_data     result byte to the transmitter (held until next capture)
//   o_tx_start    one-cycle transmit request
//   i_tx_busy     transmitter busy; no start is issued while high
//   o_busy        high while a transaction executes or waits to be sent
//   o_overrun     sticky: a byte arrived while busy and was dropped
// -----------------------------------------------------------------------------
module alu_uart_if #(
    parameter int NB_DATA      = 8,
    parameter int NB_OPERATION = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic [2:0]         o_alu_valid,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    output logic               o_busy,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        CAPTURE = 3'd4,
        SEND    = 3'd5
    } state_t;

    state_t               state_r,    state_next_s;
    logic [NB_DATA-1:0]   alu_data_r, alu_data_next_s;
    logic [2:0]           valid_r,    valid_next_s;
    logic [NB_DATA-1:0]   tx_data_r,  tx_data_next_s;
    logic                 tx_start_r, tx_start_next_s;
    logic                 busy_r,     busy_next_s;
    logic                 overrun_r,  overrun_next_s;

    // Next-state and next-output decode; every output is registered from here.
    always_comb begin
        state_next_s    = state_r;
        alu_data_next_s = alu_data_r;
        valid_next_s    = 3'b000;
        tx_data_next_s  = tx_data_r;
        tx_start_next_s = 1'b0;
        overrun_next_s  = overrun_r;

        case (state_r)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_data_next_s = i_rx_data;
                    valid_next_s    = 3'b001;
                    state_next_s    = WAIT_B;
                end else begin
                    state_next_s    = WAIT_A;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_data_next_s = i_rx_data;
                    valid_next_s    = 3'b010;
                    state_next_s    = WAIT_OP;
                end else begin
                    state_next_s    = WAIT_B;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    // Whole byte goes out untouched; the ALU decodes only the
                    // low opcode field, the upper bits ride along unchanged.
                    alu_data_next_s = {i_rx_data[NB_DATA-1:NB_OPERATION],
                                       i_rx_data[NB_OPERATION-1:0]};
                    valid_next_s    = 3'b100;
                    state_next_s    = EXEC;
                end else begin
                    state_next_s    = WAIT_OP;
                end
            end
            EXEC: begin
                // ALU latches the opcode on this edge; result is valid next cycle.
                state_next_s = CAPTURE;
                if (i_rx_done) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            CAPTURE: begin
                tx_data_next_s = i_alu_result;
                state_next_s   = SEND;
                if (i_rx_done) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    tx_start_next_s = 1'b1;
                    state_next_s    = WAIT_A;
                end else begin
                    state_next_s    = SEND;
                end
                if (i_rx_done) begin
                    overrun_next_s = 1'b1;
                end else begin
                    overrun_next_s = overrun_r;
                end
            end
            default: begin
                state_next_s = WAIT_A;
            end
        endcase

        // Busy is registered from the next state so it lines up with the state.
        busy_next_s = (state_next_s == EXEC) || (state_next_s == CAPTURE) ||
                      (state_next_s == SEND);
    end

    // State and output registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r    <= WAIT_A;
            alu_data_r <= {NB_DATA{1'b0}};
            valid_r    <= 3'b000;
            tx_data_r  <= {NB_DATA{1'b0}};
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            alu_data_r <= alu_data_next_s;
            valid_r    <= valid_next_s;
            tx_data_r  <= tx_data_next_s;
            tx_start_r <= tx_start_next_s;
            busy_r     <= busy_next_s;
            overrun_r  <= overrun_next_s;
        end
    end

    assign o_alu_data  = alu_data_r;
    assign o_alu_valid = valid_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_start  = tx_start_r;
    assign o_busy      = busy_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_alu_uart_if.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_if
// Scoreboard bench for alu_uart_if. The stimulus side pushes expected strobes
// and expected transmit bytes (with their cycle) into queues; a monitor on the
// falling edge pops and compares whenever the DUT strobes or starts a send.
// A small ALU model (operand/opcode registers + combinational result) drives
// i_alu_result.
// -----------------------------------------------------------------------------
module tb_alu_uart_if;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] rx_data;
    logic          rx_done;
    logic [NB-1:0] alu_data;
    logic [2:0]    alu_valid;
    logic [NB-1:0] alu_result;
    logic [NB-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { logic [2:0] v; logic [7:0] d; int c; } strobe_t;
    typedef struct { logic [7:0] d; int c; } tx_t;
    strobe_t strobe_q[$];
    tx_t     tx_q[$];

    int         idx = 0;
    logic [7:0] opnd [3];
    logic [7:0] last_data = 8'h00;

    alu_uart_if #(.NB_DATA(NB), .NB_OPERATION(6)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_alu_data   (alu_data),
        .o_alu_valid  (alu_valid),
        .i_alu_result (alu_result),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_busy    (tx_busy),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter: value seen at a falling edge = number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU behaviour used by both the ALU model and the scoreboard.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] op);
        case (op[5:0])
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a ^ b;
            6'h27:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    // ALU model: loads operands/opcode on their strobes.
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_op = 8'h00;
    always @(posedge clk) begin
        if (alu_valid[0]) m_a  <= alu_data;
        if (alu_valid[1]) m_b  <= alu_data;
        if (alu_valid[2]) m_op <= alu_data;
    end
    assign alu_result = alu_f(m_a, m_b, m_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one byte for the next rising edge; leaves rx_done high so a
    // following send() yields back-to-back bytes. extra is expected busy stall.
    task automatic send(input logic [7:0] b, input bit accepted, input int extra);
        strobe_t s;
        tx_t     t;
        int      p;
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        p = cyc + 1;
        if (accepted) begin
            s.v = 3'b001 << idx; s.d = b; s.c = p;
            strobe_q.push_back(s);
            opnd[idx] = b;
            if (idx == 2) begin
                t.d = alu_f(opnd[0], opnd[1], opnd[2]);
                t.c = p + 3 + extra;
                tx_q.push_back(t);
            end
            idx = (idx + 1) % 3;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_done = 1'b0;
        end
    endtask

    task automatic triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int gap);
        send(a, 1'b1, 0);
        idle(gap);
        send(b, 1'b1, 0);
        idle(gap);
        send(op, 1'b1, 0);
        idle(6);
    endtask

    // Monitor/scoreboard: compares every strobe and every transmit start.
    always @(negedge clk) begin
        strobe_t s;
        tx_t     t;
        if (!rst_n) begin
            last_data = 8'h00;
        end else begin
            if (alu_valid != 3'b000) begin
                check("valid_onehot", $countones(alu_valid), 1);
                if (strobe_q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, alu_valid}, 32'd0);
                end else begin
                    s = strobe_q.pop_front();
                    check("strobe_bits", alu_valid, s.v);
                    check("strobe_data", alu_data, s.d);
                    check("strobe_cycle", cyc, s.c);
                    check("busy_at_strobe", busy, (s.v == 3'b100));
                end
                last_data = alu_data;
            end else begin
                check("alu_data_hold", alu_data, last_data);
            end
            if (tx_start) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx_start", 1, 0);
                end else begin
                    t = tx_q.pop_front();
                    check("tx_data", tx_data, t.d);
                    check("tx_cycle", cyc, t.c);
                end
            end
        end
    end

    initial begin
        int waited;
        logic [7:0] ops [5];
        ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h27;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_alu_data", alu_data, 0);
        check("rst_alu_valid", alu_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Basic add with gaps, then sub and or.
        triple(8'h05, 8'h03, 8'h20, 2);
        check("add_result_reg", tx_data, 8'h08);
        check("idle_busy", busy, 0);
        triple(8'h03, 8'h05, 8'h22, 1);
        check("sub_result_reg", tx_data, 8'hFE);
        triple(8'hF0, 8'h0F, 8'h27, 0);
        check("or_result_reg", tx_data, 8'hFF);
        check("b2b_no_overrun", overrun, 0);

        // Transmitter busy for 10 cycles spanning SEND.
        send(8'h05, 1'b1, 0);
        send(8'h03, 1'b1, 0);
        send(8'h20, 1'b1, 7);
        tx_busy = 1'b1;
        idle(10);
        tx_busy = 1'b0;
        idle(4);
        check("busy_result_reg", tx_data, 8'h08);

        // Byte arriving during SEND is dropped and sets overrun.
        send(8'h07, 1'b1, 0);
        send(8'h02, 1'b1, 0);
        send(8'h24, 1'b1, 0);
        idle(2);
        send(8'hAA, 1'b0, 0);
        idle(3);
        check("overrun_set", overrun, 1);
        triple(8'h01, 8'h01, 8'h20, 0);
        check("overrun_sticky", overrun, 1);
        check("after_overrun_result", tx_data, 8'h02);

        // Reset mid-transaction discards partial operands.
        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b0;
        idx   = 0;
        #1;
        check("mid_rst_alu_data", alu_data, 0);
        check("mid_rst_alu_valid", alu_valid, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        triple(8'h02, 8'h03, 8'h20, 1);
        check("post_rst_result", tx_data, 8'h05);

        // Randomized transactions.
        for (int i = 0; i < 20; i++) begin
            triple(8'($urandom), 8'($urandom), ops[$urandom_range(4, 0)],
                   int'($urandom_range(2, 0)));
        end

        waited = 0;
        while ((strobe_q.size() != 0 || tx_q.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("strobe_q_drained", strobe_q.size(), 0);
        check("tx_q_drained", tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
